// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED output controller: channel mode encoding and the
// mode every channel takes out of reset.
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        LED_OFF    = 2'd0,
        LED_DIRECT = 2'd1,
        LED_PWM    = 2'd2,
        LED_BLINK  = 2'd3
    } led_mode_e;

    localparam led_mode_e LED_MODE_RST = LED_DIRECT;

endpackage

// File: rtl/led_pwm_timebase.sv
// Shared PWM timebase: prescaler, PWM counter and (with LED_PWM_CTRL_BLINK_EN)
// the blink divider that toggles blink_phase every BLINK_DIV PWM periods.
module led_pwm_timebase #(
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 1024,
    parameter int BLINK_DIV = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                tick,
    output logic                period_end,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                blink_phase
);

    localparam int              PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]     presc_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;

    // With PRESCALE=1 the prescaler is stuck at 0 and tick is permanently high
    assign tick       = (presc_reg == PS_MAX);
    assign period_end = tick && (pwm_cnt_reg == '1);
    assign pwm_cnt    = pwm_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg   <= '0;
            pwm_cnt_reg <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            if (tick)
                pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

`ifdef LED_PWM_CTRL_BLINK_EN
    localparam int              BL_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_DIV - 1);

    logic [BL_W-1:0] blink_cnt_reg;
    logic            blink_phase_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (period_end) begin
            if (blink_cnt_reg == BL_MAX) begin
                blink_cnt_reg   <= '0;
                blink_phase_reg <= ~blink_phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end

    assign blink_phase = blink_phase_reg;
`else
    localparam int BLINK_DIV_UNUSED = BLINK_DIV;
    assign blink_phase = 1'b0;
`endif

endmodule

// File: rtl/led_pwm_ctrl.sv
// Multi-channel LED controller (OFF/DIRECT/PWM/BLINK) with a single-slot config
// port committed at PWM period boundaries. BLINK needs LED_PWM_CTRL_BLINK_EN.
module led_pwm_ctrl
    import led_ctrl_pkg::*;
#(
    parameter  int NUM_LEDS  = 8,
    parameter  int PWM_BITS  = 8,
    parameter  int PRESCALE  = 1024,
    parameter  int BLINK_DIV = 64,
    localparam int CHAN_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] count,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [NUM_LEDS-1:0] leds
);

    logic                tick;
    logic                period_end;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_phase;
    logic                timebase_unused;

    led_pwm_timebase #(
        .PWM_BITS  (PWM_BITS),
        .PRESCALE  (PRESCALE),
        .BLINK_DIV (BLINK_DIV)
    ) u_timebase (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .period_end  (period_end),
        .pwm_cnt     (pwm_cnt),
        .blink_phase (blink_phase)
    );

    assign timebase_unused = tick ^ blink_phase;

    logic                pend_reg;
    logic [CHAN_W-1:0]   pend_chan_reg;
    led_mode_e           pend_mode_reg;
    logic [PWM_BITS-1:0] pend_duty_reg;
    logic                commit;

    assign cfg_ready = ~pend_reg;
    assign commit    = pend_reg && period_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg      <= 1'b0;
            pend_chan_reg <= '0;
            pend_mode_reg <= LED_MODE_RST;
            pend_duty_reg <= '0;
        end else if (cfg_valid && cfg_ready) begin
            pend_reg      <= 1'b1;
            pend_chan_reg <= cfg_chan;
            pend_mode_reg <= led_mode_e'(cfg_mode);
            pend_duty_reg <= cfg_duty;
        end else if (commit) begin
            pend_reg <= 1'b0;
        end
    end

    led_mode_e           mode_reg [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_reg [NUM_LEDS];
    logic [NUM_LEDS-1:0] leds_reg;

    assign leds = leds_reg;

    // A pending channel number >= NUM_LEDS matches no channel, so its commit is dropped
    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        logic pwm_on;
        logic led_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode_reg[gi] <= LED_MODE_RST;
                duty_reg[gi] <= '0;
            end else if (commit && (pend_chan_reg == CHAN_W'(gi))) begin
                mode_reg[gi] <= pend_mode_reg;
                duty_reg[gi] <= pend_duty_reg;
            end
        end

        assign pwm_on = (pwm_cnt < duty_reg[gi]);

        always_comb begin
            led_d = 1'b0;
            case (mode_reg[gi])
                LED_DIRECT: led_d = count[gi];
                LED_PWM:    led_d = pwm_on;
`ifdef LED_PWM_CTRL_BLINK_EN
                LED_BLINK:  led_d = pwm_on & blink_phase;
`endif
                default:    led_d = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                leds_reg[gi] <= 1'b0;
            else
                leds_reg[gi] <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Scoreboard bench for led_pwm_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor consumes them. A 5-channel instance covers out-of-range writes.
module tb_led_pwm_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] count = 4'b0000;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_chan = 2'd0;
    logic [1:0] cfg_mode = 2'd0;
    logic [3:0] cfg_duty = 4'd0;
    logic [3:0] leds;

    logic [4:0] count5 = 5'b10101;
    logic       cfg_valid5 = 1'b0;
    logic       cfg_ready5;
    logic [2:0] cfg_chan5 = 3'd0;
    logic [1:0] cfg_mode5 = 2'd0;
    logic [3:0] cfg_duty5 = 4'd0;
    logic [4:0] leds5;

    led_pwm_ctrl #(.NUM_LEDS(4), .PWM_BITS(4), .PRESCALE(2), .BLINK_DIV(2)) u_dut (
        .clk (clk), .rst_n (rst_n), .count (count),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready), .cfg_chan (cfg_chan),
        .cfg_mode (cfg_mode), .cfg_duty (cfg_duty), .leds (leds)
    );

    led_pwm_ctrl #(.NUM_LEDS(5), .PWM_BITS(4), .PRESCALE(2), .BLINK_DIV(2)) u_dut5 (
        .clk (clk), .rst_n (rst_n), .count (count5),
        .cfg_valid (cfg_valid5), .cfg_ready (cfg_ready5), .cfg_chan (cfg_chan5),
        .cfg_mode (cfg_mode5), .cfg_duty (cfg_duty5), .leds (leds5)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges since the last reset release
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int total = 0;
    int bad   = 0;

    // kind: 0 = leds, 1 = cfg_ready, 2 = leds5, 3 = cfg_ready5
    typedef struct {
        int         cyc;
        int         kind;
        logic [4:0] mask;
        logic [4:0] val;
    } exp_t;
    exp_t sb[$];

    function automatic void push(input int k, input int kind, input logic [4:0] mask,
                                 input logic [4:0] val);
        exp_t e;
        e.cyc  = k;
        e.kind = kind;
        e.mask = mask;
        e.val  = val & mask;
        sb.push_back(e);
    endfunction

    // State after j edges: pwm_cnt = (j/2)%16, blink_phase = (j/64)%2; leds lag by one
    function automatic logic pwm_at(input int k, input int duty);
        return (((k - 1) / 2) % 16) < duty;
    endfunction

    function automatic logic phase_at(input int k);
        return (((k - 1) / 64) % 2) == 1;
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            0:       return "leds";
            1:       return "cfg_ready";
            2:       return "leds5";
            default: return "cfg_ready5";
        endcase
    endfunction

    task automatic check(input string name, input int k, input logic [4:0] act,
                         input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [4:0] act;
        if (rst_n) begin
            for (int j = sb.size() - 1; j >= 0; j--) begin
                if (sb[j].cyc <= cyc) begin
                    e = sb[j];
                    case (e.kind)
                        0:       act = {1'b0, leds} & e.mask;
                        1:       act = {4'b0, cfg_ready} & e.mask;
                        2:       act = leds5 & e.mask;
                        default: act = {4'b0, cfg_ready5} & e.mask;
                    endcase
                    if (e.cyc < cyc)
                        act = ~e.val;
                    check(kname(e.kind), e.cyc, act, e.val);
                    sb.delete(j);
                end
            end
        end
    end

    task automatic at_cyc(input int k);
        while (cyc < k) @(negedge clk);
        #1;
    endtask

    task automatic cfg_write(input int c, input logic [1:0] ch, input logic [1:0] md,
                             input logic [3:0] dt);
        at_cyc(c);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_mode  = md;
        cfg_duty  = dt;
        $display("write chan=%0d mode=%0d duty=%0d issued at cyc %0d", ch, md, dt, c);
        at_cyc(c + 1);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic bl;
        repeat (3) @(negedge clk);
        #1;
        check("rst_leds",   0, {1'b0, leds}, 5'h00);
        check("rst_ready",  0, {4'b0, cfg_ready}, 5'h01);
        check("rst_leds5",  0, leds5, 5'h00);
        #1 rst_n = 1'b1;

        // Out of reset every channel is DIRECT
        at_cyc(2);
        count = 4'b1010;
        push(3, 0, 5'h0f, 5'h0a);
        push(3, 1, 5'h01, 5'h01);
        push(3, 2, 5'h1f, 5'h15);
        at_cyc(5);
        count = 4'b0101;
        push(6, 0, 5'h0f, 5'h05);
        at_cyc(7);
        count = 4'b1010;
        push(8, 0, 5'h0f, 5'h0a);
        $display("direct mode: count patterns 1010/0101/1010 queued");

        // chan 1 PWM duty 4: accepted at edge 11, committed at edge 32
        push(11, 1, 5'h01, 5'h00);
        push(31, 1, 5'h01, 5'h00);
        push(32, 1, 5'h01, 5'h01);
        push(32, 0, 5'h02, 5'h02);
        for (int k = 33; k <= 200; k++)
            push(k, 0, 5'h02, {3'b0, pwm_at(k, 4), 1'b0});
        for (int k = 33; k <= 64; k++)
            push(k, 0, 5'h0d, 5'h08);
        cfg_write(10, 2'd1, 2'd2, 4'd4);

        // chan 2 BLINK duty 15: accepted at edge 41, committed at edge 64
        push(41, 1, 5'h01, 5'h00);
        push(64, 1, 5'h01, 5'h01);
        for (int k = 65; k <= 200; k++) begin
`ifdef LED_PWM_CTRL_BLINK_EN
            bl = pwm_at(k, 15) & phase_at(k);
`else
            bl = 1'b0;
`endif
            push(k, 0, 5'h05, {2'b0, bl, 2'b0});
        end
        cfg_write(40, 2'd2, 2'd3, 4'd15);

        // chan 3 PWM duty 0 (never on), then duty 15
        push(71, 1, 5'h01, 5'h00);
        push(96, 1, 5'h01, 5'h01);
        push(96, 0, 5'h08, 5'h08);
        for (int k = 97; k <= 128; k++)
            push(k, 0, 5'h08, 5'h00);
        cfg_write(70, 2'd3, 2'd2, 4'd0);

        push(101, 1, 5'h01, 5'h00);
        push(128, 1, 5'h01, 5'h01);
        for (int k = 129; k <= 200; k++)
            push(k, 0, 5'h08, {1'b0, pwm_at(k, 15), 3'b0});

        // 5-channel instance: chan 5 is out of range, handshake only
        push(101, 3, 5'h01, 5'h00);
        push(127, 3, 5'h01, 5'h00);
        push(128, 3, 5'h01, 5'h01);
        for (int k = 96; k <= 200; k++)
            push(k, 2, 5'h1f, 5'h15);
        at_cyc(100);
        cfg_valid5 = 1'b1;
        cfg_chan5  = 3'd5;
        cfg_mode5  = 2'd0;
        cfg_duty5  = 4'd0;
        $display("write5 chan=5 mode=0 duty=0 issued at cyc 100");
        cfg_write(100, 2'd3, 2'd2, 4'd15);
        cfg_valid5 = 1'b0;

        // Pending write to chan 0 that reset must discard
        push(196, 1, 5'h01, 5'h00);
        cfg_write(195, 2'd0, 2'd2, 4'd8);

        at_cyc(200);
        check("sb_drained", 200, 5'(sb.size()), 5'h00);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_leds",  200, {1'b0, leds}, 5'h00);
        check("midrst_ready", 200, {4'b0, cfg_ready}, 5'h01);
        check("midrst_leds5", 200, leds5, 5'h00);
        $display("reset asserted mid-operation with a write pending");

        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int k = 1; k <= 70; k++)
            push(k, 0, 5'h0f, 5'h0a);
        push(1, 1, 5'h01, 5'h01);
        push(40, 1, 5'h01, 5'h01);
        at_cyc(72);
        count = 4'b0101;
        push(73, 0, 5'h0f, 5'h05);
        at_cyc(76);
        check("sb_final", 76, 5'(sb.size()), 5'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
